// File: rtl/sram_arb_if.sv
// Requester-side port of the SRAM arbiter: command, lock request, grant and read return.
// The requester drives through master; the arbiter sees slave.
interface sram_arb_if #(
  parameter int AW = 16
);
  logic          req;
  logic [3:0]    wen;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          lock;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;

  modport master (
    output req, wen, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wen, addr, wdata, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/sram_arb.sv
// Two-port round-robin arbiter with grant locking in front of a single-port 64K x 32 SRAM.
// Latency: grant same cycle; read data 1 cycle after grant, 2 with SRAM_ARB_RDATA_REG_EN defined.
// Backpressure: a requester holds its command until gnt; there is no stall on the read return.
module sram_arb #(
  parameter int AW = 16
) (
  input  logic          hclk,
  input  logic          hreset,
  sram_arb_if.slave     p0,
  sram_arb_if.slave     p1,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic [31:0]   mem_bwen,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_d,
  input  logic [31:0]   mem_q
);

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_P0   = 2'd1,
    LK_P1   = 2'd2
  } lock_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wen;
  } cmd_t;

  lock_e lock_q;
  lock_e lock_d;
  logic  last_q;
  logic  gnt0;
  logic  gnt1;
  cmd_t  cmd;
  logic  rd_issue;
  logic  rd_vld_q;
  logic  rd_tag_q;
  logic  [31:0] rdata0_q;
  logic  [31:0] rdata1_q;

  // Lock owner state register.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      lock_q <= LK_NONE;
    end else begin
      lock_q <= lock_d;
    end
  end

  // Grant selection and lock next-state. An owner that drops req loses the lock
  // in that same cycle, so the other port is not stalled by an idle owner.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    lock_d = lock_q;
    if (!hreset) begin
      if (lock_q == LK_P0 && p0.req) begin
        gnt0 = 1'b1;
      end else if (lock_q == LK_P1 && p1.req) begin
        gnt1 = 1'b1;
      end else if (p0.req && p1.req) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = p0.req;
        gnt1 = p1.req;
      end

      if (gnt0) begin
        lock_d = p0.lock ? LK_P0 : LK_NONE;
      end else if (gnt1) begin
        lock_d = p1.lock ? LK_P1 : LK_NONE;
      end else if ((lock_q == LK_P0 && !p0.req) || (lock_q == LK_P1 && !p1.req)) begin
        lock_d = LK_NONE;
      end
    end
  end

  // last_q = 1 means port 1 was granted most recently.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      last_q <= 1'b1;
    end else if (gnt0) begin
      last_q <= 1'b0;
    end else if (gnt1) begin
      last_q <= 1'b1;
    end
  end

  always_comb begin
    cmd = '{addr: p0.addr, wdata: p0.wdata, wen: p0.wen};
    if (gnt1) begin
      cmd = '{addr: p1.addr, wdata: p1.wdata, wen: p1.wen};
    end
  end

  always_comb begin
    mem_cen  = 1'b1;
    mem_wen  = 1'b1;
    mem_bwen = '1;
    mem_a    = '0;
    mem_d    = '0;
    if (gnt0 || gnt1) begin
      mem_cen = 1'b0;
      mem_wen = ~|cmd.wen;
      mem_a   = cmd.addr;
      mem_d   = cmd.wdata;
      for (int k = 0; k < 4; k++) begin
        mem_bwen[8*k +: 8] = {8{~cmd.wen[k]}};
      end
    end
  end

  assign rd_issue = (gnt0 || gnt1) && (cmd.wen == 4'b0000);

  // Read-return tag: which port owns the SRAM output in the next cycle.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      rd_vld_q <= 1'b0;
      rd_tag_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_issue;
      rd_tag_q <= gnt1;
    end
  end

  assign p0.gnt = gnt0;
  assign p1.gnt = gnt1;

`ifdef SRAM_ARB_RDATA_REG_EN
  logic rv_vld_q;
  logic rv_tag_q;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      rv_vld_q <= 1'b0;
      rv_tag_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rv_vld_q <= rd_vld_q;
      rv_tag_q <= rd_tag_q;
      if (rd_vld_q && !rd_tag_q) begin
        rdata0_q <= mem_q;
      end
      if (rd_vld_q && rd_tag_q) begin
        rdata1_q <= mem_q;
      end
    end
  end

  assign p0.rvalid = rv_vld_q && !rv_tag_q && !hreset;
  assign p1.rvalid = rv_vld_q &&  rv_tag_q && !hreset;
  assign p0.rdata  = rdata0_q;
  assign p1.rdata  = rdata1_q;
`else
  logic ret0;
  logic ret1;

  // A read in flight when reset rises is suppressed here and cleared at the edge.
  assign ret0 = rd_vld_q && !rd_tag_q && !hreset;
  assign ret1 = rd_vld_q &&  rd_tag_q && !hreset;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (ret0) begin
        rdata0_q <= mem_q;
      end
      if (ret1) begin
        rdata1_q <= mem_q;
      end
    end
  end

  assign p0.rvalid = ret0;
  assign p1.rvalid = ret1;
  assign p0.rdata  = ret0 ? mem_q : rdata0_q;
  assign p1.rdata  = ret1 ? mem_q : rdata1_q;
`endif

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb with a behavioural single-port SRAM (1-cycle read).
module tb_sram_arb;
  localparam int AW = 16;
`ifdef SRAM_ARB_RDATA_REG_EN
  localparam int RL = 2;
`else
  localparam int RL = 1;
`endif

  logic          hclk = 1'b0;
  logic          hreset;
  logic          mem_cen;
  logic          mem_wen;
  logic [31:0]   mem_bwen;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_d;
  logic [31:0]   mem_q = '0;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 hclk = ~hclk;

  sram_arb_if #(.AW(AW)) p0 ();
  sram_arb_if #(.AW(AW)) p1 ();

  sram_arb #(.AW(AW)) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .p0       (p0),
    .p1       (p1),
    .mem_cen  (mem_cen),
    .mem_wen  (mem_wen),
    .mem_bwen (mem_bwen),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_q    (mem_q)
  );

  // SRAM model; preloaded with 0x5EED_0000 | address on the first edge.
  logic [31:0] sram [0:(1<<AW)-1];
  logic        sram_init = 1'b0;

  always @(posedge hclk) begin
    if (!sram_init) begin
      for (int i = 0; i < (1 << AW); i++) begin
        sram[i] <= 32'h5EED_0000 | 32'(i);
      end
      sram_init <= 1'b1;
    end else if (!mem_cen) begin
      if (!mem_wen) begin
        sram[mem_a] <= (sram[mem_a] & mem_bwen) | (mem_d & ~mem_bwen);
      end else begin
        mem_q <= sram[mem_a];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic [3:0] w, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic l);
    p0.req = r; p0.wen = w; p0.addr = a; p0.wdata = d; p0.lock = l;
  endtask

  task automatic drv1(input logic r, input logic [3:0] w, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic l);
    p1.req = r; p1.wen = w; p1.addr = a; p1.wdata = d; p1.lock = l;
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    // Reset with both ports requesting: nothing may be granted.
    hreset = 1'b1;
    drv0(1'b1, 4'h0, 16'h0020, 32'h0, 1'b0);
    drv1(1'b1, 4'h0, 16'h0030, 32'h0, 1'b0);
    tick();
    tick();
    check("rst_gnt0",   32'(p0.gnt),    32'd0);
    check("rst_gnt1",   32'(p1.gnt),    32'd0);
    check("rst_cen",    32'(mem_cen),   32'd1);
    check("rst_wen",    32'(mem_wen),   32'd1);
    check("rst_bwen",   mem_bwen,       32'hFFFF_FFFF);
    check("rst_rv0",    32'(p0.rvalid), 32'd0);
    check("rst_rv1",    32'(p1.rvalid), 32'd0);
    check("rst_rdata0", p0.rdata,       32'h0);
    check("rst_rdata1", p1.rdata,       32'h0);

    // Both ports read every cycle for 6 cycles: grants alternate starting at port 0.
    hreset = 1'b0;
    for (int i = 0; i < 6 + RL; i++) begin
      drv0(i < 6, 4'h0, 16'(32'h20 + (i + 1) / 2), 32'h0, 1'b0);
      drv1(i < 6, 4'h0, 16'(32'h30 + i / 2),       32'h0, 1'b0);
      #1;
      if (i < 6) begin
        check("rr_gnt0", 32'(p0.gnt), 32'(i % 2 == 0));
        check("rr_gnt1", 32'(p1.gnt), 32'(i % 2 == 1));
        check("rr_addr", 32'(mem_a),  32'(((i % 2 == 0) ? 32'h20 : 32'h30) + i / 2));
      end
      if (i >= RL) begin
        j = i - RL;
        check("rr_rv0", 32'(p0.rvalid), 32'(j % 2 == 0));
        check("rr_rv1", 32'(p1.rvalid), 32'(j % 2 == 1));
        if (j % 2 == 0) check("rr_rdata0", p0.rdata, 32'h5EED_0020 + 32'(j / 2));
        else            check("rr_rdata1", p1.rdata, 32'h5EED_0030 + 32'(j / 2));
      end else begin
        check("rr_rv0_early", 32'(p0.rvalid), 32'd0);
      end
      tick();
    end

    // Port 0 full write then read back at 0x0010.
    drv1(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
    drv0(1'b1, 4'hF, 16'h0010, 32'hA5A5_5A5A, 1'b0);
    #1;
    check("wr_gnt0", 32'(p0.gnt),  32'd1);
    check("wr_gnt1", 32'(p1.gnt),  32'd0);
    check("wr_cen",  32'(mem_cen), 32'd0);
    check("wr_wen",  32'(mem_wen), 32'd0);
    check("wr_bwen", mem_bwen,     32'h0);
    check("wr_addr", 32'(mem_a),   32'h10);
    check("wr_data", mem_d,        32'hA5A5_5A5A);
    tick();
    drv0(1'b1, 4'h0, 16'h0010, 32'h0, 1'b0);
    #1;
    check("rd_gnt0",      32'(p0.gnt),    32'd1);
    check("rd_wen",       32'(mem_wen),   32'd1);
    check("rd_bwen",      mem_bwen,       32'hFFFF_FFFF);
    check("wr_no_rvalid", 32'(p0.rvalid), 32'd0);
    tick();
    drv0(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
    #1;
    check("rd_lat", 32'(p0.rvalid), 32'(RL == 1));
    repeat (RL - 1) tick();
    #1;
    check("rd_rv0",    32'(p0.rvalid), 32'd1);
    check("rd_rdata0", p0.rdata,       32'hA5A5_5A5A);
    check("rd_rv1",    32'(p1.rvalid), 32'd0);
    tick();
    check("rd_pulse",  32'(p0.rvalid), 32'd0);
    check("rd_hold",   p0.rdata,       32'hA5A5_5A5A);
    check("idle_cen",  32'(mem_cen),   32'd1);

    // Port 1 byte-lane write at the top address.
    drv1(1'b1, 4'hF, 16'hFFFF, 32'hFFFF_FFFF, 1'b0);
    #1;
    check("top_gnt1", 32'(p1.gnt), 32'd1);
    check("top_addr", 32'(mem_a),  32'hFFFF);
    tick();
    drv1(1'b1, 4'b0100, 16'hFFFF, 32'h00CC_0000, 1'b0);
    #1;
    check("lane_bwen", mem_bwen,     32'hFF00_FFFF);
    check("lane_wen",  32'(mem_wen), 32'd0);
    check("lane_data", mem_d,        32'h00CC_0000);
    tick();
    drv1(1'b1, 4'h0, 16'hFFFF, 32'h0, 1'b0);
    #1;
    check("lane_rd_gnt1", 32'(p1.gnt), 32'd1);
    tick();
    drv1(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
    repeat (RL - 1) tick();
    #1;
    check("lane_rv1",    32'(p1.rvalid), 32'd1);
    check("lane_rdata1", p1.rdata,       32'hFFCC_FFFF);
    check("lane_rv0",    32'(p0.rvalid), 32'd0);
    check("lane_rdata0", p0.rdata,       32'hA5A5_5A5A);
    tick();

    // Port 0 locks for four transfers while port 1 requests continuously.
    for (int k = 0; k < 4; k++) begin
      drv0(1'b1, 4'hF, 16'(32'h40 + k), 32'h1111_0000 | 32'(k), k < 3);
      drv1(1'b1, 4'h0, 16'h0050, 32'h0, 1'b0);
      #1;
      check("lock_gnt0", 32'(p0.gnt), 32'd1);
      check("lock_gnt1", 32'(p1.gnt), 32'd0);
      tick();
    end
    drv0(1'b1, 4'hF, 16'h0044, 32'h1111_0004, 1'b0);
    #1;
    check("unlock_gnt1", 32'(p1.gnt), 32'd1);
    check("unlock_gnt0", 32'(p0.gnt), 32'd0);
    check("unlock_addr", 32'(mem_a),  32'h50);
    tick();
    drv1(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
    #1;
    check("after_gnt0", 32'(p0.gnt),    32'd1);
    check("after_rv1",  32'(p1.rvalid), 32'(RL == 1));
    tick();
    drv0(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
    #1;
    check("after_rv1b",    32'(p1.rvalid), 32'(RL == 2));
    check("after_rdata1",  p1.rdata,       32'h5EED_0050);
    tick();

    // Reset the cycle after a port 0 read grant: the read is dropped.
    drv0(1'b1, 4'h0, 16'h0021, 32'h0, 1'b0);
    #1;
    check("pre_rst_gnt0", 32'(p0.gnt), 32'd1);
    tick();
    hreset = 1'b1;
    drv1(1'b1, 4'h0, 16'h0030, 32'h0, 1'b0);
    #1;
    check("rst2_gnt0", 32'(p0.gnt),    32'd0);
    check("rst2_gnt1", 32'(p1.gnt),    32'd0);
    check("rst2_cen",  32'(mem_cen),   32'd1);
    check("rst2_wen",  32'(mem_wen),   32'd1);
    check("rst2_bwen", mem_bwen,       32'hFFFF_FFFF);
    check("rst2_rv0",  32'(p0.rvalid), 32'd0);
    tick();
    check("rst2_rv0b",   32'(p0.rvalid), 32'd0);
    check("rst2_rv1b",   32'(p1.rvalid), 32'd0);
    check("rst2_rdata0", p0.rdata,       32'h0);
    check("rst2_rdata1", p1.rdata,       32'h0);
    hreset = 1'b0;
    #1;
    check("post_rst_gnt0", 32'(p0.gnt),    32'd1);
    check("post_rst_gnt1", 32'(p1.gnt),    32'd0);
    check("post_rst_rv0",  32'(p0.rvalid), 32'd0);
    tick();
    drv0(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
    drv1(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 SHALL have parameter AW, default 16, meaning SRAM word-address width (64K x 32 array).
REQ-002 SHALL have port hclk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port hreset  input  1  synchronous, active-high reset.
REQ-004 SHALL have per requester n in {0,1}: reqn  input  1  access request.
REQ-005 SHALL have wen_n  input  4  byte write enables, active high; 4'b0000 means read.
REQ-006 SHALL have addrn  input  AW  word address.
REQ-007 SHALL have wdatan  input  32  write data.
REQ-008 SHALL have lockn  input  1  keep the grant for the following access.
REQ-009 SHALL have gntn  output  1  request accepted this cycle.
REQ-010 SHALL have rvalidn  output  1  read data valid.
REQ-011 SHALL have rdatan  output  32  read data.
REQ-012 SHALL have SRAM-side ports: mem_cen out 1 (active low); mem_wen out 1 (active low); mem_bwen out 32 (active low per bit); mem_a out AW; mem_d out 32; mem_q in 32 (valid one cycle after a mem_cen=0 read).

Function
REQ-013 SHALL keep reqn, wen_n, addrn, wdatan and lockn stable from reqn rise until gntn is sampled high; gntn is combinational from reqn and internal state.
REQ-014 SHALL assert at most one gntn per cycle, and gntn only when reqn=1.
REQ-015 SHALL, with a single requester active and no lock held by the other port, grant it in the same cycle.
REQ-016 SHALL, on simultaneous requests and no lock, grant round-robin: the port not granted most recently wins.
REQ-017 SHALL drive the granted port's command to the SRAM in the grant cycle: mem_cen=0; mem_a=addr; mem_d=wdata; mem_wen=~|wen; mem_bwen[8k+7:8k]={8{~wen[k]}}.
REQ-018 SHALL drive mem_cen=1, mem_wen=1 and mem_bwen=all ones in any cycle without a grant.
REQ-019 SHALL set a lock owner when a granted transfer has lockn=1; while the lock is held, only the owner may be granted.
REQ-020 SHALL release the lock on the owner's next granted transfer with lockn=0, or in any cycle the owner has reqn=0.
REQ-021 SHALL, for a granted read, pulse rvalidn for one cycle with rdatan=mem_q after the read latency of REQ-027; writes produce no rvalid.
REQ-022 SHALL track read ownership in a pipeline of port-tag and valid bits so that back-to-back reads from alternating ports return in grant order without loss.
REQ-023 SHALL keep rdatan at the last returned value when rvalidn=0 (0 after reset).
REQ-024 SHALL make the last-grant pointer reflect the last granted port; an ungranted cycle SHALL leave it unchanged.

Reset
REQ-025 SHALL, while hreset=1, force gnt0=gnt1=0, mem_cen=1, mem_wen=1 and mem_bwen all ones.
REQ-026 SHALL, on reset, clear rvalid0/1, rdata0/1, the lock owner and the read pipeline, and set the last-grant pointer to port 1 so port 0 wins the first conflict; reads in flight when reset asserts SHALL be dropped.

Configuration
REQ-027 SHALL implement macro SRAM_ARB_RDATA_REG_EN: when defined, add a register stage after mem_q, so rvalidn/rdatan appear two cycles after grant; when undefined, rvalidn appears one cycle after grant with rdatan driven combinationally from mem_q.

Verification
REQ-028 SHALL cover: port0 writes addr 0x0010, data 0xA5A5_5A5A, wen 4'b1111, then reads 0x0010 -> gnt0 on both requests; rvalid0 with 0xA5A5_5A5A at 1 cycle (2 with macro).
REQ-029 SHALL cover: both ports request reads every cycle for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; each rvalid goes to the correct port in order.
REQ-030 SHALL cover: port1 writes wen 4'b0100 with data 0x00CC_0000 over 0xFFFF_FFFF at addr 0xFFFF (top address) -> a subsequent read returns 0xFFCC_FFFF.
REQ-031 SHALL cover: port0 issues 4 requests with lock0=1,1,1,0 while port1 requests continuously -> port1 gets no grant until after the 4th port0 grant, then is granted next.
REQ-032 SHALL cover: hreset asserted the cycle after a read grant -> no rvalid; all outputs at reset values; the first post-reset conflict grants port0.
